// File: rtl/axi_cmd_pkg.sv
// axi_cmd_pkg: burst encodings, FSM states, cmd_id layout and helpers shared by the AXI command generator
package axi_cmd_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    // offsets above the id field: cmd_id = {last, err, id}
    localparam int ERR_BIT  = 0;
    localparam int LAST_BIT = 1;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/axi_cmd_gen_if.sv
// axi_cmd_gen_if: AXI AW/W/AR slave channels plus the command/data FIFO push side
interface axi_cmd_gen_if #(
    parameter int AXI_ID_WIDTH = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0] awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STRB_WIDTH-1:0]   wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [AXI_ID_WIDTH-1:0] arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic                    cmd_write;
    logic [2:0]              cmd_size;
    logic [AXI_ID_WIDTH+1:0] cmd_id;
    logic                    cmd_w_en;
    logic                    cmd_fifo_full;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [STRB_WIDTH-1:0]   cmd_wstrb;
    logic                    data_w_en;
    logic                    data_fifo_full;
    logic                    err_wlast;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  cmd_fifo_full, data_fifo_full,
        output awready, wready, arready,
        output cmd_addr, cmd_write, cmd_size, cmd_id, cmd_w_en, cmd_wdata, cmd_wstrb,
        output data_w_en, err_wlast
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output cmd_fifo_full, data_fifo_full,
        input  awready, wready, arready,
        input  cmd_addr, cmd_write, cmd_size, cmd_id, cmd_w_en, cmd_wdata, cmd_wstrb,
        input  data_w_en, err_wlast
    );
endinterface

// File: rtl/axi_addr_gen.sv
// axi_addr_gen: next beat address and burst error flag for FIXED/INCR/WRAP bursts
module axi_addr_gen
    import axi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  err
);
    localparam int MAX_SIZE = clog2(STRB_WIDTH);

    logic [ADDR_WIDTH-1:0] bytes, mask, incr, wrap;
    logic                  wrap_ok;

    // reserved bursts and illegal wrap lengths fall back to INCR addressing
    always_comb begin
        bytes     = ADDR_WIDTH'(1) << size;
        mask      = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        wrap_ok   = len inside {8'd1, 8'd3, 8'd7, 8'd15};
        incr      = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        wrap      = (addr & ~mask) | ((addr + bytes) & mask);
        err       = int'(size) > MAX_SIZE || burst == BURST_RSVD || (burst == BURST_WRAP && !wrap_ok);
        next_addr = burst == BURST_FIXED ? addr : (burst == BURST_WRAP && wrap_ok) ? wrap : incr;
    end
endmodule

// File: rtl/axi_cmd_gen.sv
// axi_cmd_gen: arbitrates AW/AR round-robin and expands each burst into an ordered stream of per-beat commands
module axi_cmd_gen
    import axi_cmd_pkg::*;
#(
    parameter int AXI_ID_WIDTH = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64
) (
    input  logic          aclk,
    input  logic          aresetn,
    axi_cmd_gen_if.slave  bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic                    prio_w_q, prio_w_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, next_addr;
    logic [7:0]              len_q, len_d, cnt_q, cnt_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [AXI_ID_WIDTH-1:0] id_q, id_d;
    logic                    err_wlast_q, err_wlast_d;
    logic                    err, last, idle, grant_w, grant_r, fire;

    axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_addr_gen (
        .addr(addr_q), .len(len_q), .size(size_q), .burst(burst_q),
        .next_addr(next_addr), .err(err)
    );

    always_comb begin
        idle          = state_q == ST_IDLE;
        grant_w       = idle && bus.awvalid && (!bus.arvalid || prio_w_q);
        grant_r       = idle && bus.arvalid && (!bus.awvalid || !prio_w_q);
        last          = cnt_q == len_q;
        bus.awready   = grant_w;
        bus.arready   = grant_r;
        bus.wready    = state_q == ST_WRITE && !bus.cmd_fifo_full && !bus.data_fifo_full;
        fire          = state_q == ST_WRITE ? bus.wready && bus.wvalid : state_q == ST_READ && !bus.cmd_fifo_full;
        bus.cmd_w_en  = fire;
        bus.data_w_en = fire && state_q == ST_WRITE;
        bus.cmd_write = state_q == ST_WRITE;
        bus.cmd_addr  = addr_q;
        bus.cmd_size  = size_q;
        bus.cmd_id[AXI_ID_WIDTH+LAST_BIT] = !idle && last;
        bus.cmd_id[AXI_ID_WIDTH+ERR_BIT]  = !idle && err;
        bus.cmd_id[AXI_ID_WIDTH-1:0]      = idle ? '0 : id_q;
        bus.cmd_wdata = bus.wdata;
        bus.cmd_wstrb = bus.wstrb;
        bus.err_wlast = err_wlast_q;
        err_wlast_d   = bus.data_w_en && (bus.wlast != last);
        state_d       = state_q;
        prio_w_d      = prio_w_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        burst_d       = burst_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        if (grant_w || grant_r) begin
            state_d  = grant_w ? ST_WRITE : ST_READ;
            // the pointer only moves when both sides actually competed
            prio_w_d = (bus.awvalid && bus.arvalid) ? grant_r : prio_w_q;
            addr_d   = grant_w ? bus.awaddr : bus.araddr;
            len_d    = grant_w ? bus.awlen : bus.arlen;
            size_d   = grant_w ? bus.awsize : bus.arsize;
            burst_d  = grant_w ? bus.awburst : bus.arburst;
            id_d     = grant_w ? bus.awid : bus.arid;
            cnt_d    = '0;
        end else if (fire) begin
            addr_d  = next_addr;
            cnt_d   = cnt_q + 8'd1;
            state_d = last ? ST_IDLE : state_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            prio_w_q    <= 1'b1;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            err_wlast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_w_q    <= prio_w_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            err_wlast_q <= err_wlast_d;
        end
    end
endmodule

// File: tb/tb_axi_cmd_gen.sv
// tb_axi_cmd_gen: table of bursts with hand-computed beat addresses, plus reset and arbitration sequences
module tb_axi_cmd_gen;
    import axi_cmd_pkg::*;

    localparam int IDW = 8;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_cmd_gen_if #(.AXI_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    axi_cmd_gen #(.AXI_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(clk), .aresetn(rst_n), .bus(bus)
    );

    typedef struct {
        logic              write;
        logic [IDW-1:0]    id;
        logic [AW-1:0]     addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              err;
        logic [0:7][AW-1:0] exp;
        int                stall_at;
        int                stall_n;
        logic              stall_data;
        int                bad;
    } vec_t;

    vec_t tbl [15];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic w, input logic [IDW-1:0] id, input logic [AW-1:0] a,
                                input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                input logic err, input logic [0:7][AW-1:0] exp);
        vec_t v;
        v.write = w; v.id = id; v.addr = a; v.len = len; v.size = size; v.burst = burst;
        v.err = err; v.exp = exp; v.stall_at = 0; v.stall_n = 0; v.stall_data = 1'b0; v.bad = -1;
        return v;
    endfunction

    function automatic logic [DW-1:0] pat(input int b);
        return {32'hD00D0000 | 32'(b), 32'hCAFE0000 | 32'(b)};
    endfunction

    function automatic logic [SW-1:0] strb(input int b);
        return SW'(8'hFF ^ 8'(b));
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic post(input vec_t v);
        if (v.write) begin
            bus.awid = v.id; bus.awaddr = v.addr; bus.awlen = v.len;
            bus.awsize = v.size; bus.awburst = v.burst; bus.awvalid = 1'b1;
        end else begin
            bus.arid = v.id; bus.araddr = v.addr; bus.arlen = v.len;
            bus.arsize = v.size; bus.arburst = v.burst; bus.arvalid = 1'b1;
        end
    endtask

    task automatic wait_hs(input logic w, input string name);
        #1;
        for (int i = 0; i < 50 && !(bus.awready || bus.arready); i++) begin
            @(negedge clk);
            #1;
        end
        chk(name, {bus.awready, bus.arready, bus.cmd_w_en}, {w, !w, 1'b0});
        @(posedge clk);
        #1;
        if (w) bus.awvalid = 1'b0;
        else bus.arvalid = 1'b0;
    endtask

    task automatic set_in(input vec_t v, input int b, input int cyc);
        logic full;
        full = cyc >= v.stall_at && cyc < v.stall_at + v.stall_n;
        bus.cmd_fifo_full  = full && !v.stall_data;
        bus.data_fifo_full = full && v.stall_data;
        bus.wdata = pat(b);
        bus.wstrb = strb(b);
        bus.wlast = (b == int'(v.len)) ^ (b == v.bad);
    endtask

    task automatic run_beats(input vec_t v);
        int b = 0;
        int cyc = 0;
        logic pend = 1'b0;
        logic ef;
        logic [AW-1:0] ea;
        bus.wvalid = v.write;
        set_in(v, b, cyc);
        while (b <= int'(v.len) && cyc < 600) begin
            @(negedge clk);
            ef = !bus.cmd_fifo_full && !(v.write && bus.data_fifo_full);
            chk("ctrl", {bus.awready, bus.arready, bus.wready, bus.cmd_w_en, bus.data_w_en, bus.err_wlast},
                {2'b00, v.write && ef, ef, v.write && ef, pend});
            pend = ef && v.write && (bus.wlast != (b == int'(v.len)));
            if (bus.cmd_w_en) begin
                ea = v.len > 8'd7 ? v.addr + AW'(b) : v.exp[b];
                chk("beat", {bus.cmd_addr, bus.cmd_write, bus.cmd_size, bus.cmd_id},
                    {ea, v.write, v.size, b == int'(v.len), v.err, v.id});
                if (v.write) chk("wdata", {bus.cmd_wdata, bus.cmd_wstrb}, {pat(b), strb(b)});
                b++;
            end
            @(posedge clk);
            #1;
            cyc++;
            set_in(v, b, cyc);
        end
        bus.wvalid = 1'b0;
        bus.cmd_fifo_full = 1'b0;
        bus.data_fifo_full = 1'b0;
        chk("beat_count", b, int'(v.len) + 1);
        @(negedge clk);
        chk("turnaround", {bus.cmd_w_en, bus.data_w_en, bus.wready, bus.err_wlast}, {3'b000, pend});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(1, 8'h11, 32'h1000, 3, 3, BURST_INCR, 0, {32'h1000, 32'h1008, 32'h1010, 32'h1018, 128'h0});
        tbl[1]  = mk(0, 8'h22, 32'h1018, 3, 3, BURST_WRAP, 0, {32'h1018, 32'h1000, 32'h1008, 32'h1010, 128'h0});
        tbl[2]  = mk(0, 8'h33, 32'h2000, 1, 4, BURST_INCR, 1, {32'h2000, 32'h2010, 192'h0});
        tbl[3]  = mk(0, 8'h44, 32'h3004, 2, 2, BURST_RSVD, 1, {32'h3004, 32'h3008, 32'h300C, 160'h0});
        tbl[4]  = mk(1, 8'h55, 32'h4000, 2, 3, BURST_FIXED, 0, {32'h4000, 32'h4000, 32'h4000, 160'h0});
        tbl[5]  = mk(1, 8'h66, 32'h5008, 2, 3, BURST_WRAP, 1, {32'h5008, 32'h5010, 32'h5018, 160'h0});
        tbl[6]  = mk(0, 8'h77, 32'h6003, 2, 2, BURST_INCR, 0, {32'h6003, 32'h6004, 32'h6008, 160'h0});
        tbl[7]  = mk(1, 8'h88, 32'hFFFF_FFF8, 1, 3, BURST_INCR, 0, {32'hFFFF_FFF8, 32'h0, 192'h0});
        tbl[8]  = mk(0, 8'h99, 32'h7004, 1, 2, BURST_WRAP, 0, {32'h7004, 32'h7000, 192'h0});
        tbl[9]  = mk(1, 8'hA0, 32'h8000, 7, 3, BURST_INCR, 0, {32'h8000, 32'h8008, 32'h8010, 32'h8018,
                                                              32'h8020, 32'h8028, 32'h8030, 32'h8038});
        tbl[9].stall_at = 2; tbl[9].stall_n = 5;
        tbl[10] = mk(1, 8'hB0, 32'hA000, 1, 3, BURST_INCR, 0, {32'hA000, 32'hA008, 192'h0});
        tbl[10].stall_n = 3; tbl[10].stall_data = 1'b1;
        tbl[11] = mk(1, 8'hC0, 32'h9000, 1, 2, BURST_INCR, 0, {32'h9000, 32'h9004, 192'h0});
        tbl[11].bad = 0;
        tbl[12] = mk(0, 8'hD0, 32'hB030, 7, 3, BURST_WRAP, 0, {32'hB030, 32'hB038, 32'hB000, 32'hB008,
                                                              32'hB010, 32'hB018, 32'hB020, 32'hB028});
        tbl[13] = mk(0, 8'hD1, 32'hB030, 0, 3, BURST_INCR, 0, {32'hB030, 224'h0});
        tbl[14] = mk(0, 8'hE0, 32'hC000, 255, 0, BURST_INCR, 0, 256'h0);

        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.cmd_fifo_full = 1'b0; bus.data_fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", {bus.awready, bus.arready, bus.wready, bus.cmd_w_en, bus.data_w_en, bus.err_wlast,
                      bus.cmd_write, bus.cmd_size, bus.cmd_id, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle", {bus.awready, bus.arready, bus.wready, bus.cmd_w_en, bus.cmd_id}, '0);

        for (int i = 0; i < 15; i++) begin
            post(tbl[i]);
            wait_hs(tbl[i].write, "grant");
            run_beats(tbl[i]);
        end

        post(tbl[9]);
        wait_hs(1'b1, "grant_rst");
        bus.wvalid = 1'b1;
        bus.wlast = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid", {bus.awready, bus.arready, bus.wready, bus.cmd_w_en, bus.data_w_en, bus.err_wlast,
                          bus.cmd_write, bus.cmd_size, bus.cmd_id, bus.cmd_addr}, '0);
        bus.wvalid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        post(tbl[0]);
        post(tbl[1]);
        wait_hs(1'b1, "arb_w_first");
        run_beats(tbl[0]);
        wait_hs(1'b0, "arb_r_follow");
        run_beats(tbl[1]);
        post(tbl[4]);
        post(tbl[2]);
        wait_hs(1'b0, "arb_r_first");
        run_beats(tbl[2]);
        wait_hs(1'b1, "arb_w_follow");
        run_beats(tbl[4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
